// File: rtl/player_pkg.sv
// player_pkg
// Shared types and helpers for the music-player playlist sequencer.
//   state_t    : sequencer FSM state encoding (also driven onto debug LEDs)
//   MODE_*     : track-selection mode codes carried on the 2-bit mode input
//   NUM_TRACKS : number of song ROMs
//   track_len  : sample count of a track, selected from the per-track lengths
package player_pkg;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [1:0] MODE_ORDER   = 2'd0;
  localparam logic [1:0] MODE_SHUFFLE = 2'd1;
  localparam logic [1:0] MODE_CHOICE  = 2'd2;

  localparam int NUM_TRACKS = 4;

  function automatic int track_len(input logic [1:0] trk,
                                   input int len0, input int len1,
                                   input int len2, input int len3);
    int len;
    case (trk)
      2'd0:    len = len0;
      2'd1:    len = len1;
      2'd2:    len = len2;
      default: len = len3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/next_track_sel.sv
// next_track_sel
// Combinational track-index selection shared by end-of-track and skip paths.
//   mode     in  2  0 in-order, 1 shuffle, 2 choice, 3 behaves as 0
//   track    in  2  current track index
//   choice   in  2  selected track in choice mode
//   rand_val in  2  random track candidate for shuffle
//   dir      in  1  0 = next, 1 = previous
//   next_idx out 2  track to load
//   restart  out 1  the selection restarts the current track
module next_track_sel
  import player_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [1:0] track,
  input  logic [1:0] choice,
  input  logic [1:0] rand_val,
  input  logic       dir,
  output logic [1:0] next_idx,
  output logic       restart
);

  always_comb begin
    next_idx = track + 2'd1;
    restart  = 1'b0;
    if (mode == MODE_CHOICE) begin
      if (dir) begin
        next_idx = track;
        restart  = 1'b1;
      end else begin
        next_idx = choice;
      end
    end else if (dir) begin
      next_idx = track - 2'd1;
    end else if (mode == MODE_SHUFFLE) begin
      // never replay the track that just ended
      next_idx = (rand_val == track) ? (track + 2'd1) : rand_val;
    end
  end

endmodule

// File: rtl/playlist_sequencer.sv
// playlist_sequencer
// Track-select FSM and ROM read-address generator for the music player.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   sample_tick  : sample-rate strobe; address and gap counter advance on it
//   btn_play/stop/next/prev : one-cycle debounced button pulses
//   mode, choice, rand_val  : track-selection controls
//   track, rom_addr         : current track and ROM read address
//   audio_en     : high only while playing
//   track_done   : one-cycle pulse when the last sample of a track is reached
//   state_o      : FSM state for debug LEDs
//
// state | meaning
// STOP  | idle, address 0, waiting for play
// LOAD  | one cycle: address cleared, new track latched
// PLAY  | address advances on each sample tick
// PAUSE | address, track and gap counter frozen
// GAP   | silent ticks between tracks
module playlist_sequencer
  import player_pkg::*;
#(
  parameter int LEN0      = 270,
  parameter int LEN1      = 220,
  parameter int LEN2      = 260,
  parameter int LEN3      = 260,
  parameter int ADDR_W    = 11,
  parameter int GAP_TICKS = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic [1:0]        mode,
  input  logic [1:0]        choice,
  input  logic [1:0]        rand_val,
  output logic [1:0]        track,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              audio_en,
  output logic              track_done,
  output logic [2:0]        state_o
);

  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  state_t            state, state_nxt;
  logic [1:0]        track_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              gap_hold, hold_nxt;
  logic              done_nxt;
  logic              audio_nxt;

  logic [1:0]        sel_idx;
  logic              sel_restart;
  logic [1:0]        sel_track;
  logic              sel_dir;
  logic [ADDR_W-1:0] last_addr;
  logic              skip;
  logic              live;
  logic              at_last;
  logic              gap_end;

  // prev only acts when next is absent, so it alone picks the direction
  assign sel_dir   = btn_prev && !btn_next;
  assign sel_track = sel_restart ? track : sel_idx;

  next_track_sel u_sel (
    .mode     (mode),
    .track    (track),
    .choice   (choice),
    .rand_val (rand_val),
    .dir      (sel_dir),
    .next_idx (sel_idx),
    .restart  (sel_restart)
  );

  assign last_addr = ADDR_W'(track_len(track, LEN0, LEN1, LEN2, LEN3) - 1);
  assign at_last   = (rom_addr == last_addr);
  assign gap_end   = (gap_cnt == GAP_W'(GAP_TICKS - 1));
  assign skip      = btn_next || btn_prev;
  assign live      = (mode == MODE_CHOICE) && (choice != track);

  always_comb begin
    state_nxt = state;
    track_nxt = track;
    addr_nxt  = rom_addr;
    gap_nxt   = gap_cnt;
    hold_nxt  = gap_hold;
    done_nxt  = 1'b0;
    case (state)
      STOP: begin
        if (!btn_stop && btn_play) begin
          state_nxt = LOAD;
          track_nxt = (mode == MODE_CHOICE) ? choice : track;
        end
      end
      LOAD: begin
        state_nxt = PLAY;
        addr_nxt  = '0;
      end
      PLAY: begin
        if (btn_stop) begin
          state_nxt = STOP;
          addr_nxt  = '0;
          gap_nxt   = '0;
          hold_nxt  = 1'b0;
        end else if (btn_play) begin
          state_nxt = PAUSE;
          hold_nxt  = 1'b0;
        end else if (skip) begin
          state_nxt = LOAD;
          track_nxt = sel_track;
          addr_nxt  = '0;
        end else if (sample_tick && at_last) begin
          state_nxt = GAP;
          done_nxt  = 1'b1;
          addr_nxt  = '0;
          gap_nxt   = '0;
        end else if (live) begin
          state_nxt = LOAD;
          track_nxt = sel_track;
          addr_nxt  = '0;
        end else if (sample_tick) begin
          addr_nxt = rom_addr + 1'b1;
        end
      end
      PAUSE: begin
        if (btn_stop) begin
          state_nxt = STOP;
          addr_nxt  = '0;
          gap_nxt   = '0;
          hold_nxt  = 1'b0;
        end else if (btn_play) begin
          state_nxt = gap_hold ? GAP : PLAY;
        end else if (skip || live) begin
          // a skip while paused abandons any pending gap
          track_nxt = sel_track;
          addr_nxt  = '0;
          gap_nxt   = '0;
          hold_nxt  = 1'b0;
        end
      end
      GAP: begin
        if (btn_stop) begin
          state_nxt = STOP;
          addr_nxt  = '0;
          gap_nxt   = '0;
          hold_nxt  = 1'b0;
        end else if (btn_play) begin
          state_nxt = PAUSE;
          hold_nxt  = 1'b1;
        end else if (skip || (sample_tick && gap_end) || live) begin
          state_nxt = LOAD;
          track_nxt = sel_track;
          addr_nxt  = '0;
          gap_nxt   = '0;
        end else if (sample_tick) begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = STOP;
        addr_nxt  = '0;
        gap_nxt   = '0;
        hold_nxt  = 1'b0;
      end
    endcase
    audio_nxt = (state_nxt == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STOP;
      track      <= 2'd0;
      rom_addr   <= '0;
      gap_cnt    <= '0;
      gap_hold   <= 1'b0;
      track_done <= 1'b0;
      audio_en   <= 1'b0;
    end else begin
      state      <= state_nxt;
      track      <= track_nxt;
      rom_addr   <= addr_nxt;
      gap_cnt    <= gap_nxt;
      gap_hold   <= hold_nxt;
      track_done <= done_nxt;
      audio_en   <= audio_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_playlist_sequencer.sv
module tb_playlist_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        btn_play = 1'b0;
  logic        btn_stop = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  choice = 2'd0;
  logic [1:0]  rand_val = 2'd0;
  logic [1:0]  track;
  logic [10:0] rom_addr;
  logic        audio_en;
  logic        track_done;
  logic [2:0]  state_o;

  localparam int S_STOP = 0, S_LOAD = 1, S_PLAY = 2, S_PAUSE = 3, S_GAP = 4;

  int checks = 0;
  int failures = 0;
  int done_cnt;
  int audio_cnt;

  playlist_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .btn_play    (btn_play),
    .btn_stop    (btn_stop),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .mode        (mode),
    .choice      (choice),
    .rand_val    (rand_val),
    .track       (track),
    .rom_addr    (rom_addr),
    .audio_en    (audio_en),
    .track_done  (track_done),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    btn_play = 1'b0;
    btn_stop = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick = 1'b1;
      step();
    end
  endtask

  task automatic ticks_count(input int n, output int dn, output int au);
    dn = 0;
    au = 0;
    for (int i = 0; i < n; i++) begin
      sample_tick = 1'b1;
      step();
      if (track_done) dn++;
      if (audio_en) au++;
    end
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_state", state_o, S_STOP);
    chk("rst_track", track, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_audio", audio_en, 0);
    chk("rst_done", track_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // mode 0 start
    btn_play = 1'b1;
    step();
    chk("start_load", state_o, S_LOAD);
    chk("start_track", track, 0);
    step();
    chk("start_play", state_o, S_PLAY);
    chk("start_audio", audio_en, 1);

    // track 0 runs 270 samples
    ticks_count(269, done_cnt, audio_cnt);
    chk("t0_addr269", rom_addr, 269);
    chk("t0_no_early_done", done_cnt, 0);
    ticks(1);
    chk("t0_done", track_done, 1);
    chk("t0_gap", state_o, S_GAP);
    chk("t0_gap_addr", rom_addr, 0);
    chk("t0_gap_audio", audio_en, 0);
    step();
    chk("t0_done_once", track_done, 0);
    ticks_count(47, done_cnt, audio_cnt);
    chk("gap_silent", audio_cnt, 0);
    chk("gap_still", state_o, S_GAP);
    chk("gap_track_held", track, 0);
    ticks(1);
    chk("gap_end_load", state_o, S_LOAD);
    chk("gap_end_track", track, 1);
    chk("gap_end_addr", rom_addr, 0);
    step();

    // pause at address 100
    ticks(100);
    chk("p_addr100", rom_addr, 100);
    btn_play = 1'b1;
    step();
    chk("p_paused", state_o, S_PAUSE);
    chk("p_audio_off", audio_en, 0);
    ticks(20);
    chk("p_addr_held", rom_addr, 100);
    chk("p_still_paused", state_o, S_PAUSE);
    btn_play = 1'b1;
    step();
    chk("p_resume", state_o, S_PLAY);
    chk("p_resume_addr", rom_addr, 100);
    ticks(1);
    chk("p_addr101", rom_addr, 101);

    // mode 0 wrap from track 3
    btn_next = 1'b1;
    step();
    chk("next_t2", track, 2);
    step();
    btn_next = 1'b1;
    step();
    chk("next_t3", track, 3);
    step();
    ticks(259);
    chk("t3_play", state_o, S_PLAY);
    ticks(1);
    chk("t3_done", track_done, 1);
    ticks(48);
    chk("wrap_load", state_o, S_LOAD);
    chk("wrap_track0", track, 0);
    step();

    // shuffle from track 2
    btn_next = 1'b1;
    step();
    step();
    btn_next = 1'b1;
    step();
    chk("shuf_setup", track, 2);
    step();
    mode = 2'd1;
    rand_val = 2'd2;
    ticks(260);
    chk("shuf_gap1", state_o, S_GAP);
    ticks(48);
    chk("shuf_norepeat", track, 3);
    step();
    mode = 2'd0;
    btn_prev = 1'b1;
    step();
    chk("prev_t2", track, 2);
    step();
    mode = 2'd1;
    rand_val = 2'd0;
    ticks(260);
    ticks(48);
    chk("shuf_rand0", track, 0);
    chk("shuf_rand0_load", state_o, S_LOAD);
    step();

    // mode 2 live choice
    mode = 2'd2;
    choice = 2'd1;
    step();
    chk("live1_track", track, 1);
    step();
    ticks(5);
    chk("live_addr5", rom_addr, 5);
    choice = 2'd3;
    step();
    chk("live3_load", state_o, S_LOAD);
    chk("live3_track", track, 3);
    chk("live3_addr", rom_addr, 0);
    step();
    ticks(10);
    chk("live3_addr10", rom_addr, 10);
    btn_prev = 1'b1;
    step();
    chk("restart_load", state_o, S_LOAD);
    chk("restart_track", track, 3);
    chk("restart_addr", rom_addr, 0);
    step();

    // priority
    btn_stop = 1'b1;
    btn_next = 1'b1;
    step();
    chk("stopnext_state", state_o, S_STOP);
    chk("stopnext_track", track, 3);
    chk("stopnext_audio", audio_en, 0);
    btn_play = 1'b1;
    step();
    chk("choice_start", track, 3);
    step();
    mode = 2'd0;
    ticks(7);
    btn_play = 1'b1;
    sample_tick = 1'b1;
    step();
    chk("playtick_pause", state_o, S_PAUSE);
    chk("playtick_addr", rom_addr, 7);
    btn_next = 1'b1;
    step();
    chk("pskip_state", state_o, S_PAUSE);
    chk("pskip_track", track, 0);
    chk("pskip_addr", rom_addr, 0);
    btn_play = 1'b1;
    step();
    chk("pskip_resume", state_o, S_PLAY);
    ticks(7);
    btn_next = 1'b1;
    sample_tick = 1'b1;
    step();
    chk("nexttick_load", state_o, S_LOAD);
    chk("nexttick_addr", rom_addr, 0);
    chk("nexttick_track", track, 1);
    step();

    // pause inside the gap holds the counter
    ticks(220);
    chk("t1_gap", state_o, S_GAP);
    ticks(10);
    btn_play = 1'b1;
    step();
    chk("gp_pause", state_o, S_PAUSE);
    ticks(5);
    btn_play = 1'b1;
    step();
    chk("gp_resume_gap", state_o, S_GAP);
    ticks(37);
    chk("gp_held_cnt", state_o, S_GAP);
    ticks(1);
    chk("gp_end_load", state_o, S_LOAD);
    chk("gp_end_track", track, 2);
    step();
    ticks(260);
    ticks(5);

    // asynchronous reset mid-gap
    chk("pre_rst_gap", state_o, S_GAP);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state_o, S_STOP);
    chk("arst_track", track, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_audio", audio_en, 0);
    chk("arst_done", track_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
